// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the read-side FIFO drain: default sizes, the debug
// state encoding, the output-buffer depth and small occupancy helpers.
package fifo_rd_pkg;

   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned FRAME_LEN_DEF = 8;

   // Depth of the local output buffer; it also bounds outstanding reads.
   localparam int unsigned BUF_DEPTH = 3;
   localparam int unsigned OCC_W     = 2;

   typedef logic [OCC_W-1:0] occ_t;
   typedef logic [1:0]       ptr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_STALL = 2'd2
   } rd_state_e;

   // Words buffered plus the word still coming out of the FIFO.
   function automatic logic [2:0] pending(input occ_t occ, input logic inflight);
      return {1'b0, occ} + {2'b00, inflight};
   endfunction

   // Ring-pointer increment modulo BUF_DEPTH.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/rd_out_buffer.sv
// Three-entry register FIFO between the FIFO read port and the downstream
// valid/ready interface. Push and pop may happen in the same cycle.
module rd_out_buffer
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output occ_t              occ,
   output logic [DATA_W-1:0] head_data
);

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   occ_t occ_q, occ_d;
   logic push_ok, pop_ok;

   // Qualify requests and compute next pointers and occupancy.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      pop_ok   = pop && (occ_q != occ_t'(0));
      push_ok  = push && ((occ_q != occ_t'(BUF_DEPTH)) || pop_ok);

      if (push_ok) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   occ_d = occ_q + occ_t'(1);
         2'b01:   occ_d = occ_q - occ_t'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Word storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; occupancy decides which entries are visible.
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign occ       = occ_q;
   assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain consumer of the asynchronous FIFO. Issues reads against a
// credit of three (buffer plus one in flight), absorbs the FIFO's one-cycle
// read latency and re-presents words downstream in fixed-length frames with
// a running XOR checksum. The debug state is exported on the state port.
module fifo_rd_drain
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic              rd_clk,
   input  logic              reset,
   input  logic              empty,
   input  logic [DATA_W-1:0] data_out_fifo,
   output logic              rd_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [DATA_W-1:0] frame_sum,
   output logic [15:0]       frame_cnt,
   output rd_state_e         state
);

   localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   occ_t              occ;
   logic [DATA_W-1:0] head_data;
   logic [2:0]        pend;
   logic              hs;

   logic              inflight_q, inflight_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   rd_state_e         state_q;

   rd_out_buffer #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk       (rd_clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (data_out_fifo),
      .pop       (hs),
      .occ       (occ),
      .head_data (head_data)
   );

   // Credit and handshake decode; only registered state feeds rd_en.
   always_comb begin
      pend       = pending(occ, inflight_q);
      rd_en      = !reset && !empty && (pend < 3'(BUF_DEPTH));
      inflight_d = rd_en;
      out_valid  = (occ != occ_t'(0));
      out_data   = out_valid ? head_data : '0;
      out_last   = out_valid && (word_idx_q == LAST_IDX);
      frame_sum  = acc_q ^ out_data;
      hs         = out_valid && out_ready;
   end

   // Frame position, checksum accumulator and completed-frame counter.
   always_comb begin
      word_idx_d  = word_idx_q;
      acc_d       = acc_q;
      frame_cnt_d = frame_cnt_q;
      if (hs) begin
         if (out_last) begin
            word_idx_d  = '0;
            acc_d       = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            word_idx_d  = word_idx_q + IDX_W'(1);
            acc_d       = acc_q ^ out_data;
         end
      end
   end

   // Read-tracking and framing registers; reset drops the in-flight word.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         inflight_q  <= 1'b0;
         word_idx_q  <= '0;
         acc_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         word_idx_q  <= word_idx_d;
         acc_q       <= acc_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Debug FSM following credit usage; it does not steer the datapath.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rd_en) begin
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH, ST_STALL: begin
               if ((pend == 3'd0) && !rd_en) begin
                  state_q <= ST_IDLE;
               end else if (pend == 3'(BUF_DEPTH)) begin
                  state_q <= ST_STALL;
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a behavioural FIFO with one-cycle read latency,
// a scoreboard filled when words are loaded, and a monitor that checks each
// downstream handshake plus hold-stability and read-credit invariants.
module tb_fifo_rd_drain;
   import fifo_rd_pkg::*;

   localparam int FL = 8;

   logic        rd_clk = 1'b0;
   logic        reset = 1'b1;
   logic        empty = 1'b1;
   logic [15:0] data_out_fifo = 16'h0000;
   logic        rd_en;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic [15:0] frame_sum;
   logic [15:0] frame_cnt;
   rd_state_e   state;

   fifo_rd_drain #(
      .DATA_W    (16),
      .FRAME_LEN (FL)
   ) dut (
      .rd_clk        (rd_clk),
      .reset         (reset),
      .empty         (empty),
      .data_out_fifo (data_out_fifo),
      .rd_en         (rd_en),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .frame_sum     (frame_sum),
      .frame_cnt     (frame_cnt),
      .state         (state)
   );

   always #5 rd_clk = ~rd_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural FIFO ----------------
   logic [15:0] fifo_q[$];
   bit          toggle_en = 1'b0;
   bit          toggle_ph = 1'b0;
   bit          rd_seen   = 1'b0;

   always @(negedge rd_clk) rd_seen = rd_en;

   always @(posedge rd_clk) begin
      #2;
      if (rd_seen && fifo_q.size() != 0) data_out_fifo = fifo_q.pop_front();
      else                               data_out_fifo = 16'hDEAD;
      toggle_ph = ~toggle_ph;
      empty = (fifo_q.size() == 0) || (toggle_en && toggle_ph);
   end

   // ---------------- scoreboard model ----------------
   typedef struct {
      logic [15:0] data;
      logic        last;
      logic [15:0] sum;
   } exp_t;

   exp_t        exp_q[$];
   int          m_idx = 0;
   logic [15:0] m_acc = 16'h0000;

   task automatic load_word(input logic [15:0] w);
      exp_t e;
      fifo_q.push_back(w);
      e.data = w;
      e.sum  = m_acc ^ w;
      e.last = (m_idx == FL - 1);
      if (e.last) begin
         m_idx = 0;
         m_acc = 16'h0000;
      end else begin
         m_idx++;
         m_acc = m_acc ^ w;
      end
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   int          hs_count = 0;
   int          outstanding = 0;
   bit          held_v = 1'b0;
   logic [15:0] held_d, held_s;
   logic        held_l;
   bit          chk_idx = 1'b0;

   always @(negedge rd_clk) begin
      exp_t e;
      if (reset) begin
         held_v      = 1'b0;
         chk_idx     = 1'b0;
         outstanding = 0;
      end else begin
         if (chk_idx) begin
            check("word_idx_after_last", 32'(dut.word_idx_q), 32'd0);
            chk_idx = 1'b0;
         end
         if (rd_en) begin
            check("rd_en_while_empty", 32'(empty), 32'd0);
            outstanding++;
         end
         if (held_v) begin
            check("valid_held", 32'(out_valid), 32'd1);
            check("stall_data_stable", 32'(out_data), 32'(held_d));
            check("stall_last_stable", 32'(out_last), 32'(held_l));
            check("stall_sum_stable", 32'(frame_sum), 32'(held_s));
         end
         if (out_valid && out_ready) begin
            hs_count++;
            outstanding--;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", out_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("word_data", 32'(out_data), 32'(e.data));
               check("word_last", 32'(out_last), 32'(e.last));
               check("word_sum", 32'(frame_sum), 32'(e.sum));
            end
            if (out_last) chk_idx = 1'b1;
            held_v = 1'b0;
         end else if (out_valid) begin
            held_v = 1'b1;
            held_d = out_data;
            held_l = out_last;
            held_s = frame_sum;
         end else begin
            held_v = 1'b0;
         end
         check("outstanding_le_3", 32'(outstanding <= 3), 32'd1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !out_valid) return;
         @(posedge rd_clk); #1;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, %0d words, expected 0 pending", name, exp_q.size());
   endtask

   task automatic wait_hs(input string name, input int target);
      for (int i = 0; i < 200; i++) begin
         if (hs_count >= target) return;
         @(posedge rd_clk); #1;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, %0d handshakes, expected %0d", name, hs_count, target);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge rd_clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int base;

      // Reset then stream: empty falls during the second reset cycle.
      @(posedge rd_clk); #1;
      @(posedge rd_clk); #1;
      for (int w = 1; w <= 8; w++) load_word(16'(w));
      @(negedge rd_clk);
      check("rd_en_in_reset", 32'(rd_en), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_last", 32'(out_last), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_frame_sum", 32'(frame_sum), 32'd0);
      check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      check("reset_state", 32'(state), 32'(ST_IDLE));
      @(posedge rd_clk); #1;
      reset = 1'b0;
      @(negedge rd_clk);
      check("rd_en_first", 32'(rd_en), 32'd1);
      check("latency_valid_n", 32'(out_valid), 32'd0);
      @(negedge rd_clk);
      check("latency_valid_n1", 32'(out_valid), 32'd0);
      @(negedge rd_clk);
      check("latency_valid_n2", 32'(out_valid), 32'd1);
      for (int i = 0; i < 7; i++) begin
         @(negedge rd_clk);
         check("stream_no_gap", 32'(out_valid), 32'd1);
      end
      @(posedge rd_clk); #1;
      wait_drain("drain_stream", 50);
      idle(2);
      check("frame_cnt_after_stream", 32'(frame_cnt), 32'd1);

      // Backpressure: hold out_ready low for 10 cycles mid-stream.
      base = hs_count;
      for (int i = 0; i < 16; i++) load_word(16'h0100 + 16'(i));
      wait_hs("bp_start", base + 3);
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge rd_clk);
         if (c >= 3) check("rd_en_low_bp", 32'(rd_en), 32'd0);
      end
      check("bp_valid_held", 32'(out_valid), 32'd1);
      @(posedge rd_clk); #1;
      out_ready = 1'b1;
      wait_drain("drain_bp", 100);
      idle(2);
      check("frame_cnt_after_bp", 32'(frame_cnt), 32'd3);

      // Empty toggling every cycle.
      toggle_en = 1'b1;
      for (int i = 0; i < 8; i++) load_word(16'h0200 + 16'(3 * i));
      wait_drain("drain_toggle", 100);
      toggle_en = 1'b0;
      idle(2);
      check("frame_cnt_after_toggle", 32'(frame_cnt), 32'd4);

      // Frame wrap: three frames of alternating 0xA5A5 / 0x5A5A.
      for (int i = 0; i < 24; i++) load_word((i % 2 == 0) ? 16'hA5A5 : 16'h5A5A);
      wait_drain("drain_wrap", 100);
      idle(2);
      check("frame_cnt_after_wrap", 32'(frame_cnt), 32'd7);

      // Reset mid-frame after five words; remaining traffic is abandoned.
      base = hs_count;
      for (int i = 0; i < 8; i++) load_word(16'h0300 + 16'(i));
      wait_hs("mid_reset_start", base + 5);
      reset = 1'b1;
      exp_q.delete();
      fifo_q.delete();
      m_idx = 0;
      m_acc = 16'h0000;
      @(posedge rd_clk); #1;
      reset = 1'b0;
      @(negedge rd_clk);
      check("mid_reset_out_valid", 32'(out_valid), 32'd0);
      check("mid_reset_out_last", 32'(out_last), 32'd0);
      check("mid_reset_out_data", 32'(out_data), 32'd0);
      check("mid_reset_frame_sum", 32'(frame_sum), 32'd0);
      check("mid_reset_frame_cnt", 32'(frame_cnt), 32'd0);
      check("mid_reset_rd_en", 32'(rd_en), 32'd0);
      check("mid_reset_state", 32'(state), 32'(ST_IDLE));
      @(posedge rd_clk); #1;
      for (int i = 0; i < 8; i++) load_word(16'h0400 + 16'(i * 5));
      wait_drain("drain_after_reset", 50);
      idle(2);
      check("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);

      // Counter wrap from 0xFFFF.
      @(negedge rd_clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge rd_clk);
      release dut.frame_cnt_q;
      @(negedge rd_clk);
      check("frame_cnt_forced", 32'(frame_cnt), 32'h0000FFFF);
      @(posedge rd_clk); #1;
      for (int i = 0; i < 8; i++) load_word(16'h0500 + 16'(i));
      wait_drain("drain_cnt_wrap", 50);
      idle(2);
      check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
      check("final_state_idle", 32'(state), 32'(ST_IDLE));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
